// File: rtl/contador_programa.sv
// contador_programa: program counter and instruction-fetch stage.
//
// Fetches one instruction word at a time from instruction memory with a
// req/ack handshake and holds it for decode with a valid/ready handshake.
// On acceptance the next PC is chosen from sequential, branch or jump,
// using the sign-extended immediate returned by the extension stage.
// A fetch that waits ESPERA_MAX cycles without an ack parks the block in
// a terminal error state until reset.
//
// Optional build macro: CONTADOR_INSTR_EN adds the n_instr
// acceptance counter output.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   mem_req, mem_addr    fetch request / address (mem_addr == pc)
//   mem_ack, mem_dado    memory response strobe / instruction word
//   instr, instr_valid   registered instruction and its valid flag
//   instr_ready          decode accepts instr this cycle
//   desvio, salto        branch / jump (salto has priority), acceptance only
//   ext_imm              sign-extended immediate from the extension stage
//   pc, pc_mais4         current PC and PC + 4
//   erro                 sticky fetch-timeout flag
//   n_instr              acceptance count (CONTADOR_INSTR_EN only)
module contador_programa #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned ESPERA_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_dado,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        desvio,
  input  logic        salto,
  input  logic [31:0] ext_imm,
  output logic [31:0] pc,
  output logic [31:0] pc_mais4,
  output logic        erro
`ifdef CONTADOR_INSTR_EN
  ,
  output logic [31:0] n_instr
`endif
);

  localparam logic [1:0] OCIOSO = 2'd0;
  localparam logic [1:0] BUSCA  = 2'd1;
  localparam logic [1:0] VALIDO = 2'd2;
  localparam logic [1:0] ERRO   = 2'd3;

  // The counter holds the number of ack-less BUSCA cycles already seen, so
  // the ESPERA_MAX-th ack-less cycle is the one where it equals LIMITE.
  localparam logic [7:0] LIMITE = 8'(ESPERA_MAX - 1);

  logic [1:0]  estado_q, estado_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [7:0]  espera_q, espera_d;
  logic        erro_q, erro_d;

  logic        aceite;
  logic [31:0] pc_seq, pc_salto, pc_desvio;

  assign pc_seq    = pc_q + 32'd4;
  assign pc_salto  = {pc_seq[31:28], ext_imm[25:0], 2'b00};
  assign pc_desvio = pc_seq + (ext_imm << 2);
  assign aceite    = (estado_q == VALIDO) && instr_ready;

  always_comb begin
    estado_d = estado_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    espera_d = espera_q;
    erro_d   = erro_q;
    case (estado_q)
      OCIOSO: estado_d = BUSCA;
      BUSCA: begin
        // An ack in the limit cycle still completes the fetch.
        if (mem_ack) begin
          instr_d  = mem_dado;
          espera_d = '0;
          estado_d = VALIDO;
        end else if (espera_q == LIMITE) begin
          erro_d   = 1'b1;
          estado_d = ERRO;
        end else begin
          espera_d = espera_q + 8'd1;
        end
      end
      VALIDO: begin
        if (aceite) begin
          if (salto)       pc_d = pc_salto;
          else if (desvio) pc_d = pc_desvio;
          else             pc_d = pc_seq;
          estado_d = BUSCA;
        end
      end
      ERRO: estado_d = ERRO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= OCIOSO;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      espera_q <= '0;
      erro_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      espera_q <= espera_d;
      erro_q   <= erro_d;
    end
  end

  assign mem_req     = (estado_q == BUSCA);
  assign mem_addr    = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (estado_q == VALIDO);
  assign pc          = pc_q;
  assign pc_mais4    = pc_seq;
  assign erro        = erro_q;

`ifdef CONTADOR_INSTR_EN
  logic [31:0] n_instr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      n_instr_q <= '0;
    else if (aceite) n_instr_q <= n_instr_q + 32'd1;
  end

  assign n_instr = n_instr_q;
`endif

endmodule

// File: tb/tb_contador_programa.sv
module tb_contador_programa;

  localparam int unsigned ESP = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_dado;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        desvio;
  logic        salto;
  logic [31:0] ext_imm;
  logic [31:0] pc;
  logic [31:0] pc_mais4;
  logic        erro;
`ifdef CONTADOR_INSTR_EN
  logic [31:0] n_instr;
`endif

  contador_programa #(
    .RESET_PC  (32'h0000_0000),
    .ESPERA_MAX(ESP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_dado   (mem_dado),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .desvio     (desvio),
    .salto      (salto),
    .ext_imm    (ext_imm),
    .pc         (pc),
    .pc_mais4   (pc_mais4),
    .erro       (erro)
`ifdef CONTADOR_INSTR_EN
    ,
    .n_instr    (n_instr)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Scoreboard: words the memory model has delivered, oldest first.
  logic [31:0] exp_q[$];

  // Memory model controls.
  logic mem_mute = 1'b0;
  int   force_delay = -1;
  int   wait_left = 0;

  // Reference model state (kept by the monitor).
  logic [31:0] m_pc = 32'h0;
  logic        m_valid = 1'b0;
  logic        m_err = 1'b0;
  int          m_busca = 0;
  logic [31:0] m_acc = 32'h0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Instruction memory: acks after a random (or forced) number of request
  // cycles, and sometimes strobes a stray ack while no request is pending.
  initial begin
    mem_ack = 1'b0;
    mem_dado = '0;
    forever begin
      @(posedge clk); #2;
      if (!mem_mute) begin
        mem_ack = 1'b0;
        if (rst_n && mem_req) begin
          if (wait_left == 0) begin
            mem_ack = 1'b1;
            mem_dado = $urandom;
            exp_q.push_back(mem_dado);
          end else begin
            wait_left--;
          end
        end else begin
          wait_left = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
          if ($urandom_range(0, 3) == 0) begin
            mem_ack = 1'b1;
            mem_dado = $urandom;
          end
        end
      end
    end
  end

  // Monitor: compares outputs with the model, then advances the model using
  // the inputs that the coming rising edge will see.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_pc", pc, 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_req", {31'd0, mem_req}, 32'd0);
      chk("rst_erro", {31'd0, erro}, 32'd0);
      exp_q.delete();
      m_pc = 32'h0;
      m_valid = 1'b0;
      m_err = 1'b0;
      m_busca = 0;
      m_acc = 32'h0;
    end else begin
      chk("pc", pc, m_pc);
      chk("mem_addr", mem_addr, m_pc);
      chk("pc_mais4", pc_mais4, m_pc + 32'd4);
      chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
      chk("erro", {31'd0, erro}, {31'd0, m_err});
      if (m_err || m_valid) chk("req_idle", {31'd0, mem_req}, 32'd0);
      if (instr_valid && exp_q.size() > 0) chk("instr_held", instr, exp_q[0]);
`ifdef CONTADOR_INSTR_EN
      chk("n_instr", n_instr, m_acc);
`endif
      if (mem_req && mem_ack) begin
        m_valid = 1'b1;
        m_busca = 0;
      end else if (mem_req) begin
        m_busca++;
        if (m_busca == ESP) m_err = 1'b1;
      end
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
          chk("instr", instr, exp_q.pop_front());
        end
        m_valid = 1'b0;
        m_acc = m_acc + 32'd1;
        if (salto) begin
          logic [31:0] p4;
          p4 = m_pc + 32'd4;
          m_pc = {p4[31:28], ext_imm[25:0], 2'b00};
        end else if (desvio) begin
          m_pc = m_pc + 32'd4 + ext_imm * 32'd4;
        end else begin
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #4;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #2;
      if (instr_valid) return;
    end
    chk("timeout_valid", 32'd1, 32'd0);
  endtask

  task automatic wait_req(output logic [31:0] addr);
    addr = 'x;
    for (int i = 0; i < 100; i++) begin
      if (mem_req) begin
        addr = mem_addr;
        return;
      end
      @(posedge clk); #2;
    end
    chk("timeout_req", 32'd1, 32'd0);
  endtask

  task automatic wait_req_rise(output logic [31:0] addr);
    for (int i = 0; i < 100 && mem_req; i++) begin
      @(posedge clk); #2;
    end
    wait_req(addr);
  endtask

  task automatic accept(input logic s, input logic d, input logic [31:0] imm,
                        output logic [31:0] addr);
    wait_valid();
    instr_ready = 1'b1;
    salto = s;
    desvio = d;
    ext_imm = imm;
    @(posedge clk); #2;
    instr_ready = 1'b0;
    salto = 1'b0;
    desvio = 1'b0;
    chk("req_after_accept", {31'd0, mem_req}, 32'd1);
    wait_req(addr);
  endtask

  // Branch to an absolute word address from wherever the model says pc is.
  task automatic land(input logic [31:0] target);
    logic [31:0] a;
    wait_valid();
    accept(1'b0, 1'b1, (target - m_pc - 32'd4) >> 2, a);
    chk("land", a, target);
  endtask

  initial begin
    logic [31:0] a;
    int cnt;
    rst_n = 1'b0;
    instr_ready = 1'b0;
    desvio = 1'b0;
    salto = 1'b0;
    ext_imm = '0;
    repeat (3) @(posedge clk);
    #4 rst_n = 1'b1;

    // Sequential fetch, ack one cycle after each request.
    force_delay = 1;
    instr_ready = 1'b1;
    wait_req(a);       chk("seq0", a, 32'h0);
    wait_req_rise(a);  chk("seq1", a, 32'h4);
    wait_req_rise(a);  chk("seq2", a, 32'h8);
    instr_ready = 1'b0;
    force_delay = -1;

    // Randomised traffic.
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #2;
      instr_ready = 1'($urandom_range(0, 1));
      salto = ($urandom_range(0, 7) == 0);
      desvio = ($urandom_range(0, 3) == 0);
      ext_imm = $urandom;
    end
    instr_ready = 1'b0;
    salto = 1'b0;
    desvio = 1'b0;

    // Jump, then jump with branch also high.
    land(32'h0000_0010);
    accept(1'b1, 1'b0, 32'h0000_0040, a); chk("jump", a, 32'h0000_0100);
    land(32'h0000_0010);
    accept(1'b1, 1'b1, 32'h0000_0040, a); chk("jump_prio", a, 32'h0000_0100);

    // Backward branch and wrap-around branch.
    land(32'h0000_0020);
    accept(1'b0, 1'b1, 32'hFFFF_FFFC, a); chk("branch_back", a, 32'h0000_0014);
    land(32'hFFFF_FFF8);
    accept(1'b0, 1'b1, 32'h0000_0002, a); chk("branch_wrap", a, 32'h0000_0004);

    // Backpressure: five stalled cycles with desvio toggling, then accept.
    land(32'h0000_0200);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      instr_ready = 1'b0;
      desvio = i[0];
      ext_imm = $urandom;
      @(posedge clk); #2;
      chk("bp_req", {31'd0, mem_req}, 32'd0);
      chk("bp_pc", pc, 32'h0000_0200);
    end
    instr_ready = 1'b1;
    desvio = 1'b0;
    @(posedge clk); #2;
    instr_ready = 1'b0;
    chk("bp_accept", mem_addr, 32'h0000_0204);

    // Timeout with no ack at all.
    @(posedge clk); #3;
    mem_mute = 1'b1;
    mem_ack = 1'b0;
    do_reset();
    wait_req(a);
    cnt = 0;
    while (mem_req && cnt < 40) begin
      cnt++;
      @(posedge clk); #2;
    end
    chk("timeout_cycles", cnt, ESP);
    for (int i = 0; i < 10; i++) begin
      chk("erro_sticky", {31'd0, erro}, 32'd1);
      chk("erro_noreq", {31'd0, mem_req}, 32'd0);
      @(posedge clk); #2;
    end

    // Ack in the limit cycle wins.
    force_delay = ESP - 1;
    mem_mute = 1'b0;
    do_reset();
    wait_req(a);
    cnt = 0;
    while (mem_req && cnt < 40) begin
      cnt++;
      @(posedge clk); #2;
    end
    chk("late_ack_cycles", cnt, ESP);
    chk("late_ack_erro", {31'd0, erro}, 32'd0);
    chk("late_ack_valid", {31'd0, instr_valid}, 32'd1);
    force_delay = 1;

    // Reset mid-fetch, stray ack right after release.
    instr_ready = 1'b1;
    repeat (20) @(posedge clk);
    #3;
    mem_mute = 1'b1;
    mem_ack = 1'b0;
    instr_ready = 1'b0;
    for (int i = 0; i < 20 && !mem_req; i++) begin
      @(posedge clk); #3;
    end
    chk("midfetch_req", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;
    #1;
    mem_ack = 1'b1;
    mem_dado = 32'hDEAD_BEEF;
    @(posedge clk); #2;
    mem_ack = 1'b0;
    chk("post_rst_req", {31'd0, mem_req}, 32'd1);
    chk("post_rst_addr", mem_addr, 32'h0);
    chk("post_rst_instr", instr, 32'h0);
    @(posedge clk); #2;
    chk("stray_ack_valid", {31'd0, instr_valid}, 32'd0);
    chk("stray_ack_instr", instr, 32'h0);
`ifdef CONTADOR_INSTR_EN
    chk("n_instr_rst", n_instr, 32'd0);
`endif
    force_delay = 0;
    mem_mute = 1'b0;
    instr_ready = 1'b1;
    wait_req_rise(a);
    wait_req_rise(a);
    wait_req_rise(a);
    chk("three_accepts", a, 32'h0000_000C);
`ifdef CONTADOR_INSTR_EN
    chk("n_instr_3", n_instr, 32'd3);
`endif
    instr_ready = 1'b0;
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/contador_programa.md
Name: contador_programa

Overview:
- Program-counter and instruction-fetch stage directly upstream of the immediate sign-extension stage.
- Fetches from instruction memory with a req/ack handshake and holds the instruction for decode with a valid/ready handshake.
- Decode extracts the 16-bit immediate and 26-bit target fields from this block's instr output. The sign-extended result returns here as ext_imm to compute the next PC for branch and jump.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ESPERA_MAX, 15, number of FETCH cycles without mem_ack before the fetch-timeout error; legal range 1..255.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- mem_req  output  1  fetch request to instruction memory.
- mem_addr  output  32  fetch address; always equals pc.
- mem_ack  input  1  memory response strobe; mem_dado is valid in this cycle.
- mem_dado  input  32  instruction word from memory.
- instr  output  32  registered instruction to decode and the extension stage.
- instr_valid  output  1  instr is valid and awaiting acceptance.
- instr_ready  input  1  decode accepts instr this cycle.
- desvio  input  1  branch taken; sampled only in the acceptance cycle.
- salto  input  1  jump; sampled only in the acceptance cycle; has priority over desvio.
- ext_imm  input  32  sign-extended value from the extension stage.
- pc  output  32  current PC.
- pc_mais4  output  32  pc + 4, combinational, modulo 2^32.
- erro  output  1  sticky fetch-timeout flag.

Behaviour:
- Reset (asynchronous, rst_n low):
  - pc=RESET_PC, instr=0, instr_valid=0, mem_req=0, erro=0.
  - Wait counter cleared; state=OCIOSO.
- States: OCIOSO, BUSCA, VALIDO, ERRO.
- OCIOSO: one cycle after reset release, then go to BUSCA unconditionally.
- BUSCA:
  - mem_req=1, mem_addr=pc; wait counter increments each cycle mem_ack=0.
  - On mem_ack=1: instr<=mem_dado, counter cleared, go to VALIDO. instr_valid rises the cycle after ack (1-cycle latency).
  - Counter reaching ESPERA_MAX with mem_ack=0: go to ERRO, erro<=1.
  - mem_ack in the same cycle the limit would be reached: the ack wins, no error.
- VALIDO:
  - mem_req=0, instr_valid=1, instr stable.
  - On instr_ready=1 (acceptance), pc is updated as follows:
    - salto=1: pc <= {pc_mais4[31:28], ext_imm[25:0], 2'b00}.
    - else desvio=1: pc <= pc_mais4 + (ext_imm << 2), truncated to 32 bits (wrap-around allowed).
    - else: pc <= pc_mais4.
  - After acceptance: instr_valid<=0, go to BUSCA. mem_req reasserts the cycle after acceptance.
  - instr_ready=0: hold everything; desvio/salto/ext_imm are ignored.
- ERRO: terminal; mem_req=0, instr_valid=0, erro=1, pc frozen; exit only by reset.
- mem_ack outside BUSCA is ignored; mem_dado is not sampled.
- instr_ready outside VALIDO is ignored.
- Reset mid-fetch or mid-hold: immediate return to reset values. An ack arriving in OCIOSO after reset release is ignored.
- pc[1:0] is never forced; RESET_PC must be word-aligned.

Optional Feature:
- Macro CONTADOR_INSTR_EN.
- Defined:
  - Adds output n_instr (32 bits), reset to 0, incremented by 1 on every acceptance.
  - Wraps 0xFFFF_FFFF -> 0; frozen in ERRO.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Sequential fetch, RESET_PC=0, ack 1 cycle after each req, instr_ready=1 -> mem_addr 0x0, 0x4, 0x8. instr_valid rises 1 cycle after each ack; instr equals the corresponding mem_dado.
- Jump: pc=0x0000_0010, salto=1, ext_imm=0x0000_0040 at acceptance -> next mem_addr=0x0000_0100. Same with desvio=1 also high -> still 0x0000_0100.
- Branch backward: pc=0x0000_0020, desvio=1, ext_imm=0xFFFF_FFFC -> next pc=0x0000_0014. Branch with pc=0xFFFF_FFF8, ext_imm=0x2 -> pc=0x0000_0004 (wrap).
- Backpressure: instr_ready=0 for 5 cycles, desvio toggling -> instr and pc stable, mem_req=0. Acceptance on cycle 6 uses only that cycle's desvio.
- Timeout: mem_ack held 0 with ESPERA_MAX=15 -> erro=1 and mem_req=0 after 15 BUSCA cycles, remains so; ack on cycle 15 instead -> erro stays 0.
- Reset mid-BUSCA with ack arriving 1 cycle after release -> pc=RESET_PC, instr=0, ack ignored, first req at mem_addr=RESET_PC. With CONTADOR_INSTR_EN, n_instr=0 after reset and 3 after 3 acceptances.
